// File: rtl/nes_oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies a 256-byte page into PPU OAM.
// Optional macro OAM_DMA_ALIGN_EN inserts one ALIGN cycle when the HALT cycle lands on odd parity.
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    output logic        dma_own,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_din,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3
`ifdef OAM_DMA_ALIGN_EN
        ,
        S_ALIGN = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        busy_q, busy_d;
    logic        dma_own_q, dma_own_d;
    logic        dma_rd_q, dma_rd_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic        oam_we_q, oam_we_d;
`ifdef OAM_DMA_ALIGN_EN
    logic        cyc_odd_q, cyc_odd_d;
`endif

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
`ifdef OAM_DMA_ALIGN_EN
        cyc_odd_d = ~cyc_odd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = cyc_odd_q ? S_ALIGN : S_READ;
`else
                state_d = S_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: state_d = S_READ;
`endif
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                // idx 255 is the final byte; the copy never wraps into a second pass.
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it.
        cpu_rdy_d  = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        dma_own_d  = (state_d == S_READ) || (state_d == S_WRITE);
        dma_rd_d   = (state_d == S_READ);
        dma_addr_d = (state_d == S_READ) ? {page_d, idx_d} : 16'h0000;
        oam_we_d   = (state_d == S_WRITE);
        oam_addr_d = (state_d == S_WRITE) ? idx_d : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            cpu_rdy_q  <= 1'b1;
            busy_q     <= 1'b0;
            dma_own_q  <= 1'b0;
            dma_rd_q   <= 1'b0;
            dma_addr_q <= 16'h0000;
            oam_addr_q <= 8'h00;
            oam_we_q   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            cpu_rdy_q  <= cpu_rdy_d;
            busy_q     <= busy_d;
            dma_own_q  <= dma_own_d;
            dma_rd_q   <= dma_rd_d;
            dma_addr_q <= dma_addr_d;
            oam_addr_q <= oam_addr_d;
            oam_we_q   <= oam_we_d;
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q  <= cyc_odd_d;
`endif
        end
    end

    assign cpu_rdy   = cpu_rdy_q;
    assign busy      = busy_q;
    assign dma_own   = dma_own_q;
    assign dma_rd    = dma_rd_q;
    assign dma_addr  = dma_addr_q;
    assign oam_addr  = oam_addr_q;
    assign oam_we    = oam_we_q;
    // RAM data only arrives during WRITE, so it is forwarded gated by the registered strobe.
    assign oam_data  = oam_we_q ? dma_din : 8'h00;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Bench for nes_oam_dma: random pages and RAM contents checked every cycle against a
// transfer-level model (cycle offset since trigger), plus literal pins for stall length and addresses.
module tb_nes_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_rdy;
    logic        dma_own;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_din;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        busy;
    logic [2:0]  dbg_state;

    nes_oam_dma #(.DMA_REG_ADDR(16'h4014)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .dma_own(dma_own), .dma_addr(dma_addr), .dma_rd(dma_rd),
        .dma_din(dma_din), .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: RAM, OAM, logs ----------------
    logic [7:0]  ram [65536];
    logic [7:0]  ram_dout;
    logic [7:0]  tb_oam [256];
    int          oam_seq [256];
    logic [15:0] rd_log [8192];
    int          rd_count = 0;
    int          we_count = 0;
    int          stall_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          cmp_en;

    assign dma_din = ram_dout;

    always @(posedge clk) begin
        if (dma_rd) begin
            ram_dout <= ram[dma_addr];
            rd_log[13'(rd_count)] <= dma_addr;
            rd_count <= rd_count + 1;
        end
        if (oam_we) begin
            tb_oam[oam_addr] <= oam_data;
            oam_seq[oam_addr] <= we_count + 1;
            we_count <= we_count + 1;
        end
    end

    always @(negedge clk) if (rst_n && !cpu_rdy) stall_cnt <= stall_cnt + 1;

    // ---------------- behavioural model ----------------
    // k = cycles since the trigger edge: 1 = HALT, optional ALIGN, then READ/WRITE pairs.
    bit         m_active;
    int         m_k;
    int         m_edges;
    logic [7:0] m_page;
    bit         m_align;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_edges  <= 0;
            m_page   <= 8'h00;
            m_align  <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            if (m_active) begin
                if (m_k + 1 == 514 + int'(m_align)) begin
                    m_active <= 1'b0;
                    m_k      <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (cpu_we && cpu_addr == 16'h4014) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_page   <= cpu_dout;
                m_align  <= ALIGN_EN && (((m_edges + 1) % 2) == 1);
            end
        end
    end

    // {cpu_rdy, busy, dma_own, dma_rd, oam_we, dma_addr, oam_addr, oam_data}
    function automatic logic [36:0] model_out();
        int j;
        logic [7:0] b;
        if (!m_active) return {1'b1, 36'd0};
        if (m_k == 1 || (m_align && m_k == 2)) return {1'b0, 1'b1, 35'd0};
        j = m_k - 2 - int'(m_align);
        b = 8'(j / 2);
        if (j % 2 == 0) return {5'b01110, m_page, b, 8'h00, 8'h00};
        return {5'b01101, 16'h0000, b, ram[{m_page, b}]};
    endfunction

    wire logic [36:0] got_vec = {cpu_rdy, busy, dma_own, dma_rd, oam_we, dma_addr, oam_addr, oam_data};

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    always @(negedge clk) if (cmp_en) check("cycle_outputs", 64'(got_vec), 64'(model_out()));

    // ---------------- driver tasks ----------------
    task automatic do_write(input bit now, input logic [15:0] a, input logic [7:0] d);
        if (!now) @(negedge clk);
        cpu_addr = a;
        cpu_dout = d;
        cpu_we   = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic start_dma(input logic [7:0] pg, input bit now, input int want_par,
                             output int s0, output int r0, output int w0, output bit odd);
        if (!now) @(negedge clk);
        if (want_par >= 0 && ((m_edges + 1) % 2) != want_par) @(negedge clk);
        odd = ((m_edges + 1) % 2) == 1;
        s0 = stall_cnt;
        r0 = rd_count;
        w0 = we_count;
        do_write(1'b1, 16'h4014, pg);
    endtask

    task automatic finish_dma(input string name, input logic [7:0] pg, input int s0,
                              input int r0, input int w0, input int exp_stall);
        int n = 0;
        int bad = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < 1000);
        check({name, "_done"}, 64'(busy), 64'd0);
        check({name, "_stall"}, 64'(stall_cnt - s0), 64'(exp_stall));
        check({name, "_reads"}, 64'(rd_count - r0), 64'd256);
        for (int i = r0; i < rd_count; i++) if (rd_log[13'(i)][15:8] !== pg) bad++;
        check({name, "_page"}, 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (tb_oam[i] !== ram[{pg, 8'(i)}] || oam_seq[i] <= w0) bad++;
        check({name, "_oam"}, 64'(bad), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, r0, w0, n;
        bit odd;
        logic [7:0]  pg;
        logic [15:0] a;
        int bad;

        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        cpu_we   = 1'b0;
        cmp_en   = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(got_vec), 64'({1'b1, 36'd0}));
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Non-trigger writes near and away from the DMA register
        do_write(1'b0, 16'h4013, 8'h02);
        do_write(1'b0, 16'h4015, 8'h02);
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4016;
            do_write(1'b0, a, 8'($urandom));
        end
        @(negedge clk);
        #1 check("nontrig_idle", 64'({busy, cpu_rdy}), 64'b01);

        // Basic copy of page $02 with even HALT parity
        start_dma(8'h02, 1'b0, 0, s0, r0, w0, odd);
        #1 check("halt_visible", 64'({busy, cpu_rdy}), 64'b10);
        finish_dma("basic", 8'h02, s0, r0, w0, 513);
        check("basic_first_addr", 64'(rd_log[13'(r0)]), 64'h0200);
        check("basic_last_addr", 64'(rd_log[13'(rd_count - 1)]), 64'h02FF);
        check("basic_oam_10", 64'(tb_oam[8'h10]), 64'hB5);
        check("basic_oam_ff", 64'(tb_oam[8'hFF]), 64'h5A);

        // Alignment: odd HALT parity adds a cycle only when the feature is built in
        pg = 8'($urandom_range(4, 255));
        start_dma(pg, 1'b0, 1, s0, r0, w0, odd);
        finish_dma("align_odd", pg, s0, r0, w0, ALIGN_EN ? 514 : 513);
        pg = 8'($urandom_range(4, 255));
        start_dma(pg, 1'b0, 0, s0, r0, w0, odd);
        finish_dma("align_even", pg, s0, r0, w0, 513);

        // Re-triggers during a transfer of page $03 are ignored
        start_dma(8'h03, 1'b0, -1, s0, r0, w0, odd);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(20, 120)) @(negedge clk);
            do_write(1'b0, 16'h4014, 8'h07);
        end
        finish_dma("retrig", 8'h03, s0, r0, w0, 513 + int'(ALIGN_EN && odd));
        repeat (4) @(negedge clk);
        #1 check("retrig_stays_idle", 64'({busy, cpu_rdy}), 64'b01);

        // Back-to-back transfers, each triggered in the first IDLE cycle
        for (int t = 0; t < 3; t++) begin
            pg = 8'($urandom);
            start_dma(pg, (t != 0), -1, s0, r0, w0, odd);
            finish_dma("random", pg, s0, r0, w0, 513 + int'(ALIGN_EN && odd));
        end

        // Reset while byte 100 is being read
        pg = 8'($urandom);
        start_dma(pg, 1'b0, -1, s0, r0, w0, odd);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((we_count - w0) < 100 && n < 400);
        check("midop_reached", 64'(we_count - w0), 64'd100);
        rst_n = 1'b0;
        #1 check("midop_reset_out", 64'({cpu_rdy, busy, dma_own, dma_rd, oam_we}), 64'b10000);
        repeat (3) @(negedge clk);
        check("midop_no_more_we", 64'(we_count - w0), 64'd100);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < 100 && (tb_oam[i] !== ram[{pg, 8'(i)}] || oam_seq[i] <= w0)) bad++;
            if (i >= 100 && oam_seq[i] > w0) bad++;
        end
        check("midop_partial_oam", 64'(bad), 64'd0);
        #2 rst_n = 1'b1;
        pg = 8'($urandom);
        start_dma(pg, 1'b0, -1, s0, r0, w0, odd);
        finish_dma("after_reset", pg, s0, r0, w0, 513 + int'(ALIGN_EN && odd));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
